// File: rtl/serial_pkg.sv
//==============================================================================
// Module  : serial_pkg
// Brief   : Shared FSM state type and line-level constants for the deserialiser.
// Revision: 1.0
//==============================================================================
`default_nettype none

package serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_bit_counter.sv
//==============================================================================
// Module  : serial_bit_counter
// Brief   : Data-bit counter; done flags the strobe carrying the last data bit.
// Revision: 1.0
//==============================================================================
`default_nettype none

module serial_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign done = inc && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/serial_frame_deser.sv
//==============================================================================
// Module  : serial_frame_deser
// Brief   : Start/data/[parity]/stop deserialiser with a one-entry valid/ready
//           output buffer. Define PARITY_CHECK_EN to expect an even-parity bit.
// Revision: 1.0
//==============================================================================
`default_nettype none

module serial_frame_deser #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    import serial_pkg::*;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_busy;
    logic               r_ferr;
    logic               r_ovr;
    logic [WIDTH-1:0]   w_shift_next;
    logic               w_hs;
    logic               w_clr;
    logic               w_inc;
    logic               w_done;
    logic               w_frame_ok;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shift_next = {din, r_shift[WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_shift_next = {r_shift[WIDTH-2:0], din};
        end
    endgenerate

    assign w_hs  = r_valid && out_ready;
    assign w_clr = din_en && (r_state == IDLE) && (din == START_BIT);
    assign w_inc = din_en && (r_state == DATA);

    serial_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .inc  (w_inc),
        .done (w_done)
    );

`ifdef PARITY_CHECK_EN
    logic r_par;
    // Even parity: the parity bit equals the XOR of the data bits.
    assign w_frame_ok = (din == STOP_BIT) && (r_par == ^r_shift);
`else
    assign w_frame_ok = (din == STOP_BIT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (din_en) begin
                case (r_state)
                    IDLE: begin
                        if (din == START_BIT) begin
                            r_state <= DATA;
                            r_busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        r_shift <= w_shift_next;
                        if (w_done) begin
`ifdef PARITY_CHECK_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
`ifdef PARITY_CHECK_EN
                    PARITY: begin
                        r_par   <= din;
                        r_state <= STOP;
                    end
`endif
                    STOP: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (!w_frame_ok) begin
                            r_ferr <= 1'b1;
                        end else if (!r_valid || w_hs) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            // Buffer occupied and not draining: keep the old word.
                            r_ovr <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule

`default_nettype wire
